// File: rtl/geofence_mul_arb.sv
// Round-robin arbiter sharing one pipelined signed multiplier among the geofence compute units.
// Each result is returned LAT cycles after acceptance, tagged back to the requester that issued it.
module geofence_mul_arb #(
  parameter int N_REQ = 3,
  parameter int A_W   = 12,
  parameter int LAT   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*A_W-1:0]   op_a,
  input  logic [N_REQ*A_W-1:0]   op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [2*A_W-1:0]       rsp_prod,
  output logic                   busy
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]        gnt_raw;
  logic [PTR_W-1:0]        gnt_idx;
  logic                    found;
  logic [31:0]             idx;
  logic                    accept;

  logic signed [A_W-1:0]   a_sel, b_sel;
  logic signed [2*A_W-1:0] prod_d;

  logic [LAT-1:0]          vld_q;
  logic [PTR_W-1:0]        tag_q  [LAT];
  logic signed [2*A_W-1:0] prod_q [LAT];

  // First asserted request at or after the pointer wins, wrapping modulo N_REQ.
  always_comb begin
    gnt_raw = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + 32'(k);
      if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        found                      = 1'b1;
        gnt_idx                    = idx[PTR_W-1:0];
        gnt_raw[idx[PTR_W-1:0]]    = 1'b1;
      end
    end
  end

  assign gnt    = (reset || flush) ? '0 : gnt_raw;
  assign accept = |gnt;
  assign ptr_d  = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign a_sel  = op_a[gnt_idx*A_W +: A_W];
  assign b_sel  = op_b[gnt_idx*A_W +: A_W];
  assign prod_d = a_sel * b_sel;

  // Data registers only load behind a valid op so rsp_prod holds between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_q[s]  <= '0;
        prod_q[s] <= '0;
      end
    end else if (flush) begin
      ptr_q <= '0;
      vld_q <= '0;
    end else begin
      if (accept) begin
        ptr_q     <= ptr_d;
        tag_q[0]  <= gnt_idx;
        prod_q[0] <= prod_d;
      end
      vld_q[0] <= accept;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          tag_q[s]  <= tag_q[s-1];
          prod_q[s] <= prod_q[s-1];
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (vld_q[LAT-1]) rsp_valid[tag_q[LAT-1]] = 1'b1;
  end

  assign rsp_prod = prod_q[LAT-1];
  assign busy     = |vld_q;

endmodule

// File: doc/geofence_mul_arb.md
Name: geofence_mul_arb

Overview:
- Shares one pipelined signed multiplier between the geofence sub-units that need products:
  - the angle-sort unit (cross products);
  - the shoelace area unit;
  - the Heron/side-length unit.
- Round-robin arbitration, one accepted operation per cycle, fixed latency, result routed back to the requester that issued it.
- Sits between the geofence control FSM's compute units and the single multiplier instance in geofence.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- A_W, 12, signed operand width (coordinate differences plus guard bit).
- LAT, 2, multiplier pipeline depth in cycles (1..4).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of all in-flight operations (asserted between objects).
- req  in  N_REQ  per-requester operation request; held until granted.
- op_a  in  N_REQ*A_W  flattened signed operand A; slice i belongs to requester i.
- op_b  in  N_REQ*A_W  flattened signed operand B; slice i belongs to requester i.
- gnt  out  N_REQ  one-hot grant, combinational from req/pointer/flush/reset.
- rsp_valid  out  N_REQ  one-hot, one-cycle result strobe to the issuing requester.
- rsp_prod  out  2*A_W  signed product, valid while any rsp_valid bit is high.
- busy  out  1  high when any pipeline stage holds a valid operation.

Behaviour:
- Reset (async, active-high):
  - rr pointer=0; all pipeline valid bits=0.
  - rsp_valid=0, rsp_prod=0, busy=0.
  - gnt forced 0 while reset is high.
- Acceptance: op from requester i accepted at the rising edge where req[i]&gnt[i]=1. op_a/op_b slices are captured at that edge with requester tag i.
- Requester must hold req and operands stable until granted; after a grant it may drop req or present a new op the next cycle.
- Arbitration:
  - At most one gnt bit high.
  - Search starts at the pointer index, wraps modulo N_REQ; the first asserted req wins.
  - After a grant to i, pointer <= (i+1) mod N_REQ.
  - No req: pointer unchanged, gnt=0.
  - A single requester holding req continuously is granted every cycle (back-to-back throughput 1/cycle).
- Latency: op accepted at edge E -> rsp_valid[tag] high and rsp_prod valid for exactly the cycle following edge E+LAT-1 (i.e. registered output updated at edge E+LAT-1; LAT=1 means visible right after E). Results return in acceptance order, one per cycle max, never merged.
- Arithmetic:
  - rsp_prod = signed(op_a) * signed(op_b), full 2*A_W width, no truncation or saturation.
  - Extreme case: -2^(A_W-1) squared = 2^(2*A_W-2), fits.
- rsp_prod holds its last value when no rsp_valid is high; it is not required to be cleared.
- flush:
  - When high at an edge, all pipeline valid bits are cleared, pointer <= 0, and no operation is accepted (gnt=0 during a flush cycle).
  - Results of flushed ops are never strobed.
  - The first new op may be granted the cycle after flush deasserts.
- busy = OR of pipeline valid bits, including the output stage while rsp_valid is high.
- Reset mid-operation: in-flight ops discarded immediately; no rsp_valid after reset release until a new op is accepted.
- Requesters with req low never receive gnt or rsp_valid.

Test Plan:
- Reset: assert reset mid-stream with 2 ops in flight -> rsp_valid=0 at once, busy=0; after release, first grant goes to requester 0 when all req=1.
- Single op, LAT=2: req[1]=1, op_a=-5, op_b=7 -> gnt=3'b010 that cycle; rsp_valid=3'b010 with rsp_prod=-35 exactly one cycle later than an LAT=1 build, single-cycle pulse.
- All three req held for 6 cycles -> grant order 0,1,2,0,1,2; responses in the same order, each routed to its own requester, products correct.
- Extremes (A_W=12): op_a=op_b=-2048 -> 4194304; op_a=2047, op_b=-2048 -> -4192256; op_a=0, op_b=-1 -> 0.
- Fairness: req[0] constant, req[2] constant, req[1]=0 -> alternating grants 0,2,0,2; requester 1 never granted and never sees rsp_valid.
- flush with 2 ops in flight and req[0]=1 -> gnt=0 in the flush cycle; no rsp_valid for the flushed ops; next cycle gnt[0]=1 with pointer restarted at 0.
